ecc_apb_sequencer: RTL and testbench
====================================

Name: ecc_apb_sequencer

Overview:
APB master that sequences one ECC encoder/decoder operation per request. It takes a request over a valid/ready handshake, writes the ECC block's four configuration registers over APB, then waits for operation_done. It returns data_out and num_of_errors to the requester over a second valid/ready handshake. It sits between the test/system requester and the ECC_ENC_DEC APB slave, replacing hand-driven APB stimulus.

Parameters:
DATA_WIDTH, 32, width of ECC data_out and rsp_data
AMBA_ADDR_WIDTH, 20, PADDR width
AMBA_WORD, 32, PWDATA, req_data and req_noise width
BASE_ADDR, 0, ECC block base address; register offsets are added to it
TIMEOUT_CYCLES, 64, WAIT_DONE cycles allowed before a timeout response (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  sequencer can accept a request
req_op  in  2  0=ENCODE, 1=DECODE, 2=FULL, 3=illegal
req_width  in  2  codeword width code: 0=8, 1=16, 2=32, 3=illegal
req_data  in  AMBA_WORD  value for DATA_IN
req_noise  in  AMBA_WORD  value for NOISE
PADDR  out  AMBA_ADDR_WIDTH  APB address
PWDATA  out  AMBA_WORD  APB write data
PENABLE  out  1  APB enable
PSEL  out  1  APB select
PWRITE  out  1  APB write (always 1 when PSEL is high)
operation_done  in  1  ECC completion pulse
data_out  in  DATA_WIDTH  ECC result data
num_of_errors  in  2  ECC error count
rsp_valid  out  1  response available
rsp_ready  in  1  requester accepts the response
rsp_data  out  DATA_WIDTH  captured data_out
rsp_num_errors  out  2  captured num_of_errors
rsp_status  out  2  0=OK, 1=TIMEOUT, 2=ILLEGAL
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst=1 at an edge): state IDLE, all outputs 0 except req_ready=1. Reset mid-transfer drops PSEL/PENABLE on the next edge. Any pending response is discarded.
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP. A 2-bit register index idx selects the transfer.
- IDLE: req_ready=1. When req_valid&req_ready, latch op, width, data and noise.
  - Legal request -> SETUP with idx=0.
  - Illegal op or width -> RESP with status=ILLEGAL, data=0, errors=0, and no APB traffic.
- Write order (offsets from BASE_ADDR): idx0 DATA_IN 0x04, idx1 CODEWORD_WIDTH 0x08, idx2 NOISE 0x0C, idx3 CTRL 0x00. CTRL is written last because it starts the operation. Width and op are zero-extended into PWDATA.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR and PWDATA for idx. Next state is ACCESS.
- ACCESS: PSEL=1, PENABLE=1, same PADDR and PWDATA.
  - idx<3: idx++, go to SETUP. PSEL stays high; there is no idle cycle between transfers.
  - idx=3: go to WAIT_DONE. PSEL=PENABLE=0 on the next cycle.
- The slave has no PREADY, so each transfer is exactly 2 cycles. Accept at edge 0 means APB occupies cycles 1-8 and WAIT_DONE starts at cycle 9.
- PADDR, PWDATA and PWRITE hold their last values when PSEL=0; verification must not check them then.
- WAIT_DONE: a timeout counter counts from 0.
  - operation_done=1: capture data_out and num_of_errors, status=OK, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: status=TIMEOUT, data=0, errors=0, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
  - operation_done outside WAIT_DONE is ignored.
- RESP: rsp_valid=1. rsp_* stay stable until rsp_valid&rsp_ready, then the block goes to IDLE and rsp_valid drops.
- req_ready is low outside IDLE. The earliest next accept is the cycle after the response handshake.
- Minimum legal latency from accept edge to rsp_valid is 10 cycles, with done on the first WAIT_DONE cycle.

Decomposition:
- Package ecc_seq_pkg holds:
  - op_e and width_e enums
  - status_e enum
  - state_e enum
  - register offset constants: CTRL_OFF, DATA_IN_OFF, CW_WIDTH_OFF, NOISE_OFF
  - the idx-to-offset mapping function
- One natural sub-module, ecc_seq_timer: a load/enable counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset, then req op=ENCODE, width=8, data=0x000000A5, noise=0.
   - Required APB sequence: writes 0x04=0xA5, 0x08=0x0, 0x0C=0x0, 0x00=0x0, each as SETUP then ACCESS, PSEL high for 8 consecutive cycles.
   - operation_done with data_out=0x1A5 -> rsp_data=0x1A5, status=OK.
2. op=DECODE, width=32, noise=0x00000001, done with num_of_errors=1 -> rsp_num_errors=1, status=OK, CTRL write value=1.
3. No operation_done, TIMEOUT_CYCLES=64 -> rsp_valid 64 cycles after WAIT_DONE entry, status=TIMEOUT, rsp_data=0.
4. req_op=3 -> no PSEL activity, rsp_valid on the cycle after accept, status=ILLEGAL.
5. rsp_ready held low 5 cycles with a done pulse arriving meanwhile -> rsp_* stable, second pulse ignored, req_ready low until the handshake.
6. rst asserted during idx2 ACCESS -> PSEL=PENABLE=0 next cycle, req_ready=1, no rsp_valid; a following request completes normally.

Source files
------------

// File: rtl/ecc_seq_pkg.sv
// ecc_seq_pkg: shared types, register map and helpers for the ECC APB sequencer
package ecc_seq_pkg;
  typedef enum logic [1:0] {OP_ENCODE, OP_DECODE, OP_FULL, OP_ILLEGAL} op_e;
  typedef enum logic [1:0] {W_8, W_16, W_32, W_ILLEGAL} width_e;
  typedef enum logic [1:0] {ST_OK, ST_TIMEOUT, ST_ILLEGAL} status_e;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_e;
  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] DATA_IN_OFF  = 8'h04;
  localparam logic [7:0] CW_WIDTH_OFF = 8'h08;
  localparam logic [7:0] NOISE_OFF    = 8'h0C;
  function automatic logic [7:0] reg_off(input logic [1:0] idx);
    return idx == 2'd0 ? DATA_IN_OFF : idx == 2'd1 ? CW_WIDTH_OFF : idx == 2'd2 ? NOISE_OFF : CTRL_OFF;
  endfunction
  function automatic logic is_illegal(input logic [1:0] op, input logic [1:0] width);
    return op == 2'(OP_ILLEGAL) || width == 2'(W_ILLEGAL);
  endfunction
endpackage

// File: rtl/ecc_seq_timer.sv
// ecc_seq_timer: clearable up-counter flagging the last cycle of a TIMEOUT_CYCLES window
module ecc_seq_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || load) cnt <= '0;
    else if (en && !tc) cnt <= cnt + CW'(1);
  assign tc = cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: APB master that programs one ECC operation per request and returns its result
module ecc_apb_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int BASE_ADDR       = 0,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [1:0]                 req_width,
  input  logic [AMBA_WORD-1:0]       req_data,
  input  logic [AMBA_WORD-1:0]       req_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PENABLE,
  output logic                       PSEL,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_num_errors,
  output logic [1:0]                 rsp_status,
  output logic                       busy
);
  state_e state, state_n;
  logic [1:0] idx;
  op_e op_q;
  width_e width_q;
  logic [AMBA_WORD-1:0] data_q, noise_q, wdata_c, wdata_q;
  logic [AMBA_ADDR_WIDTH-1:0] addr_c, addr_q;
  logic write_q, accept, tc;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0] rerr_q;
  status_e status_q;
  ecc_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .load(state != WAIT_DONE), .en(state == WAIT_DONE), .tc(tc)
  );
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign accept    = req_valid && req_ready;
  assign PSEL      = state == SETUP || state == ACCESS;
  assign PENABLE   = state == ACCESS;
  assign addr_c    = AMBA_ADDR_WIDTH'(BASE_ADDR) + AMBA_ADDR_WIDTH'(reg_off(idx));
  assign wdata_c   = idx == 2'd0 ? data_q : idx == 2'd1 ? AMBA_WORD'(width_q) : idx == 2'd2 ? noise_q : AMBA_WORD'(op_q);
  assign PADDR     = PSEL ? addr_c : addr_q;
  assign PWDATA    = PSEL ? wdata_c : wdata_q;
  assign PWRITE    = PSEL || write_q;
  assign rsp_valid      = state == RESP;
  assign rsp_data       = rdata_q;
  assign rsp_num_errors = rerr_q;
  assign rsp_status     = status_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = accept ? (is_illegal(req_op, req_width) ? RESP : SETUP) : IDLE;
      SETUP:     state_n = ACCESS;
      ACCESS:    state_n = idx == 2'd3 ? WAIT_DONE : SETUP;
      WAIT_DONE: state_n = operation_done || tc ? RESP : WAIT_DONE;
      RESP:      state_n = rsp_ready ? IDLE : RESP;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      op_q     <= OP_ENCODE;
      width_q  <= W_8;
      data_q   <= '0;
      noise_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= '0;
      status_q <= ST_OK;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q    <= op_e'(req_op);
        width_q <= width_e'(req_width);
        data_q  <= req_data;
        noise_q <= req_noise;
      end
      if (state == IDLE) idx <= '0;
      else if (state == ACCESS) idx <= idx + 2'd1;
      if (PSEL) begin
        addr_q  <= addr_c;
        wdata_q <= wdata_c;
        write_q <= 1'b1;
      end
      if (state_n == RESP && state != RESP) begin
        rdata_q  <= state == WAIT_DONE && operation_done ? data_out : '0;
        rerr_q   <= state == WAIT_DONE && operation_done ? num_of_errors : 2'd0;
        status_q <= state == IDLE ? ST_ILLEGAL : operation_done ? ST_OK : ST_TIMEOUT;
      end
    end
endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer: table, hand-written and random transactions checked against a cycle-level model
module tb_ecc_apb_sequencer;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = '0, req_width = '0;
  logic [31:0] req_data = '0, req_noise = '0;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic PENABLE, PSEL, PWRITE;
  logic operation_done = 1'b0;
  logic [31:0] data_out = '0;
  logic [1:0] num_of_errors = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0] rsp_num_errors, rsp_status;
  logic busy;
  int tests = 0, fails = 0;
  typedef struct {
    logic [1:0] op, width;
    logic [31:0] data, noise;
    int dly;
    logic [31:0] dout;
    logic [1:0] nerr;
    int hold;
    bit early, late;
    int e_lat;
    logic [1:0] e_st;
    logic [31:0] e_data;
    logic [1:0] e_nerr;
  } vec_t;
  vec_t tbl[8];
  ecc_apb_sequencer #(.DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .BASE_ADDR(0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_width(req_width), .req_data(req_data), .req_noise(req_noise), .PADDR(PADDR),
    .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL), .PWRITE(PWRITE),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_num_errors(rsp_num_errors), .rsp_status(rsp_status), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.op == 2'd3 || v.width == 2'd3) begin
      r.e_lat = 1; r.e_st = 2'd2; r.e_data = '0; r.e_nerr = '0;
    end else if (v.dly < TO) begin
      r.e_lat = 10 + v.dly; r.e_st = 2'd0; r.e_data = v.dout; r.e_nerr = v.nerr;
    end else begin
      r.e_lat = 9 + TO; r.e_st = 2'd1; r.e_data = '0; r.e_nerr = '0;
    end
    return r;
  endfunction
  task automatic run(input vec_t v, input string tag);
    logic [51:0] wq[$];
    logic [51:0] ew[4];
    bit legal, pat_ok, wr_ok, hold_ok;
    int c, n;
    legal = v.op != 2'd3 && v.width != 2'd3;
    ew = '{{20'h4, v.data}, {20'h8, 30'd0, v.width}, {20'hC, v.noise}, {20'h0, 30'd0, v.op}};
    req_op = v.op; req_width = v.width; req_data = v.data; req_noise = v.noise; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, " accept_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = $urandom; req_noise = $urandom; req_op = 2'($urandom); req_width = 2'($urandom);
    c = 1; pat_ok = 1;
    while (!rsp_valid && c < 200) begin
      if (PSEL !== (legal && c <= 8) || PENABLE !== (legal && c <= 8 && (c % 2) == 0)) pat_ok = 0;
      if (busy !== 1'b1 || req_ready !== 1'b0 || (PSEL && PWRITE !== 1'b1)) pat_ok = 0;
      if (PSEL && PENABLE) wq.push_back({PADDR, PWDATA});
      operation_done = (c == 9 + v.dly) || (v.early && c == 4);
      data_out = operation_done ? v.dout : $urandom;
      num_of_errors = operation_done ? v.nerr : 2'($urandom);
      @(posedge clk); #1; c++;
    end
    operation_done = 1'b0; data_out = $urandom;
    chk({tag, " latency"}, 64'(c), 64'(v.e_lat));
    chk({tag, " apb_pattern"}, 64'(pat_ok), 64'd1);
    wr_ok = wq.size() == (legal ? 4 : 0);
    if (wr_ok && legal) for (int i = 0; i < 4; i++) if (wq[i] !== ew[i]) wr_ok = 0;
    chk({tag, " apb_writes"}, 64'(wr_ok), 64'd1);
    chk({tag, " status"}, 64'(rsp_status), 64'(v.e_st));
    chk({tag, " data"}, 64'(rsp_data), 64'(v.e_data));
    chk({tag, " nerr"}, 64'(rsp_num_errors), 64'(v.e_nerr));
    hold_ok = 1;
    for (int h = 0; h < v.hold; h++) begin
      operation_done = v.late && h == 1;
      data_out = $urandom; num_of_errors = 2'($urandom);
      @(posedge clk); #1;
      if (!rsp_valid || req_ready || rsp_status !== v.e_st || rsp_data !== v.e_data || rsp_num_errors !== v.e_nerr) hold_ok = 0;
    end
    operation_done = 1'b0;
    if (v.hold > 0) chk({tag, " hold_stable"}, 64'(hold_ok), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " release"}, 64'({rsp_valid, req_ready, busy}), 64'(3'b010));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t v;
    bit idle_ok;
    tbl[0] = '{2'd0, 2'd0, 32'hA5, 32'h0, 0, 32'h1A5, 2'd0, 0, 1'b0, 1'b0, 10, 2'd0, 32'h1A5, 2'd0};
    tbl[1] = '{2'd1, 2'd2, 32'h12345678, 32'h1, 3, 32'hDEADBEEF, 2'd1, 0, 1'b1, 1'b0, 13, 2'd0, 32'hDEADBEEF, 2'd1};
    tbl[2] = '{2'd2, 2'd1, 32'hCAFEF00D, 32'h3, 999, 32'h0, 2'd0, 0, 1'b0, 1'b0, 73, 2'd1, 32'h0, 2'd0};
    tbl[3] = '{2'd3, 2'd0, 32'h1111, 32'h2222, 0, 32'h5, 2'd1, 0, 1'b0, 1'b0, 1, 2'd2, 32'h0, 2'd0};
    tbl[4] = '{2'd0, 2'd3, 32'h33, 32'h44, 0, 32'h5, 2'd1, 2, 1'b0, 1'b1, 1, 2'd2, 32'h0, 2'd0};
    tbl[5] = '{2'd0, 2'd1, 32'h55AA, 32'h0, 1, 32'h55AA, 2'd2, 5, 1'b0, 1'b1, 11, 2'd0, 32'h55AA, 2'd2};
    tbl[6] = '{2'd2, 2'd2, 32'hABCDEF01, 32'hF0, 63, 32'h77, 2'd3, 0, 1'b0, 1'b0, 73, 2'd0, 32'h77, 2'd3};
    tbl[7] = '{2'd1, 2'd0, 32'h5A, 32'h0, 62, 32'h99, 2'd1, 1, 1'b0, 1'b0, 72, 2'd0, 32'h99, 2'd1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({req_ready, PSEL, PENABLE, PWRITE, rsp_valid, busy, rsp_status, rsp_num_errors}), 64'(10'b1000000000));
    chk("reset_bus", 64'({PADDR, PWDATA}), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("tbl%0d", i));
    req_op = 2'd0; req_width = 2'd1; req_data = 32'h77; req_noise = 32'h3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midrst_in_idx2_access", 64'({PSEL, PENABLE, PADDR, PWDATA}), 64'({1'b1, 1'b1, 20'hC, 32'h3}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_after", 64'({PSEL, PENABLE, req_ready, rsp_valid, busy}), 64'(5'b00100));
    idle_ok = 1;
    for (int k = 0; k < 12; k++) begin
      operation_done = k == 3;
      @(posedge clk); #1;
      if (rsp_valid || PSEL || !req_ready) idle_ok = 0;
    end
    operation_done = 1'b0;
    chk("midrst_idle", 64'(idle_ok), 64'd1);
    run(tbl[0], "post_rst");
    for (int i = 0; i < 30; i++) begin
      v.op = 2'($urandom_range(0, 3)); v.width = 2'($urandom_range(0, 3));
      v.data = $urandom; v.noise = $urandom; v.dly = $urandom_range(0, 70);
      v.dout = $urandom; v.nerr = 2'($urandom); v.hold = $urandom_range(0, 3);
      v.early = $urandom_range(0, 3) == 0; v.late = $urandom_range(0, 1) == 1;
      run(model(v), $sformatf("rnd%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
